alu_ctrl_seq: RTL
=================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter FUNC_W, default 4, width of the R-type Function field.
REQ-002 SHALL have parameter CTRL_W, default 4, width of ALU_Control (minimum 4).
REQ-003 SHALL have parameter MUL_LAT, default 4, MUL latency in cycles (minimum 2).
REQ-004 SHALL have parameter DIV_LAT, default 16, DIV latency in cycles (minimum 2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  ALUOp/Function valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts an op this cycle.
REQ-009 SHALL have port ALUOp  input  2  op class from main control: 11 add (lw/sw/addi), 10 slt (slti), 01 sub (beq), 00 R-type.
REQ-010 SHALL have port Function  input  FUNC_W  R-type function code.
REQ-011 SHALL have port Flush  input  1  abort any op in progress.
REQ-012 SHALL have port ALU_Control  output  CTRL_W  registered ALU operation select.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse: ALU_Control result complete.
REQ-014 SHALL have port MDU_Start  output  1  one-cycle pulse launching the multiply/divide datapath.
REQ-015 SHALL have port Stall  output  1  pipeline hold while a multi-cycle op runs.
REQ-016 SHALL have port Illegal  output  1  one-cycle pulse: undefined R-type Function accepted.

Function
REQ-017 Encodings SHALL be ADD 0, SUB 1, AND 2, OR 3, SLT 4, XOR 5, NOR 6, SLL 7, SRL 8, MUL 9, DIV 10, zero-extended to CTRL_W; R-type Function values 0..10 map to the same codes.
REQ-018 ALUOp 11/10/01 SHALL decode to ADD/SLT/SUB regardless of Function.
REQ-019 R-type Function > 10 SHALL decode to ADD and pulse Illegal with out_valid.
REQ-020 Acceptance SHALL occur when in_valid & in_ready; in_ready = (state==IDLE) & ~Flush.
REQ-021 FSM states SHALL be IDLE and BUSY only.
REQ-022 Single-cycle op accepted in cycle N: ALU_Control updated and out_valid=1 in cycle N+1; state stays IDLE (back-to-back accepts allowed every cycle).
REQ-023 MUL/DIV accepted in cycle N: go BUSY at N+1, MDU_Start=1 in N+1 only, counter loaded with LAT-1.
REQ-024 In BUSY the counter SHALL decrement each cycle; ALU_Control holds MUL/DIV; Stall=1; in_ready=0.
REQ-025 When the counter is 0 in BUSY: out_valid=1 that cycle (cycle N+LAT), return to IDLE next cycle.
REQ-026 Flush in BUSY SHALL return to IDLE next cycle with no out_valid; Flush in IDLE SHALL drop any offered op.
REQ-027 Flush and counter==0 in the same cycle: Flush wins, out_valid=0.
REQ-028 Counter width SHALL be clog2(max(MUL_LAT,DIV_LAT)); no wrap below 0.
REQ-029 out_valid, MDU_Start, Illegal SHALL be 0 in every cycle not named above.

Reset
REQ-030 reset SHALL override all inputs, including Flush and in_valid.
REQ-031 After reset: state IDLE, counter 0, ALU_Control ADD (0), out_valid 0, MDU_Start 0, Stall 0, Illegal 0, in_ready 1 in the following cycle.
REQ-032 reset asserted in BUSY SHALL abort the op with no out_valid.

Structure
REQ-033 Package alu_ctrl_pkg SHALL hold the ALU op enum, ALUOp class constants and FSM state typedef.
REQ-034 The latency counter SHALL be a sub-module mdu_lat_counter (load, decrement, zero flag).

Verification
REQ-035 Reset then ALUOp=00 Function=2 accepted at N -> ALU_Control=2, out_valid=1 at N+1, Stall=0.
REQ-036 ALUOp=00 Function=9 at N, MUL_LAT=4 -> MDU_Start at N+1, Stall N+1..N+4, out_valid at N+4 with ALU_Control=9, in_ready=1 at N+5.
REQ-037 DIV (Function=10) then Flush at N+5 -> no out_valid, IDLE and in_ready=1 at N+6.
REQ-038 ALUOp=01 Function=15, then ALUOp=00 Function=13 back-to-back -> SUB/out_valid, then ADD/out_valid with Illegal=1.
REQ-039 Flush and counter==0 same cycle; reset mid-DIV -> no out_valid, all outputs at reset values.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control sequencer: op encodings, ALUOp classes, FSM states.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLT = 4'd4,
    OP_XOR = 4'd5,
    OP_NOR = 4'd6,
    OP_SLL = 4'd7,
    OP_SRL = 4'd8,
    OP_MUL = 4'd9,
    OP_DIV = 4'd10
  } alu_op_e;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam int unsigned FUNC_MAX = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    illegal;
  } dec_t;

  // Map ALUOp class plus R-type function code to an ALU op; undefined codes become ADD + illegal.
  function automatic dec_t decode(input logic [1:0] aluop, input logic [31:0] fn);
    dec_t d;
    d.op      = OP_ADD;
    d.illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: d.op = OP_ADD;
      ALUOP_SLT: d.op = OP_SLT;
      ALUOP_SUB: d.op = OP_SUB;
      default: begin
        if (fn > 32'(FUNC_MAX)) begin
          d.illegal = 1'b1;
        end else begin
          d.op = alu_op_e'(fn[3:0]);
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Down-counter timing a multi-cycle MUL/DIV; saturates at zero.
module mdu_lat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a two-state sequencer for multi-cycle MUL/DIV.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNC_W  = 4,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [FUNC_W-1:0] Function,
  input  logic              Flush,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic              out_valid,
  output logic              MDU_Start,
  output logic              Stall,
  output logic              Illegal
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT);

  state_e           state;
  logic             valid_q;
  logic             cnt_zero_c;
  logic             accept_c;
  logic             is_mdu_c;
  dec_t             dec_c;
  logic [CNT_W-1:0] load_val_c;

  // Handshake and decode of the offered op.
  assign in_ready   = (state == ST_IDLE) & ~Flush & ~reset;
  assign accept_c   = in_valid & in_ready;
  assign dec_c      = decode(ALUOp, 32'(Function));
  assign is_mdu_c   = (dec_c.op == OP_MUL) || (dec_c.op == OP_DIV);
  assign load_val_c = (dec_c.op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);

  // Multi-cycle completion fires in the last BUSY cycle unless flushed or reset.
  assign Stall     = (state == ST_BUSY);
  assign out_valid = valid_q | ((state == ST_BUSY) & cnt_zero_c & ~Flush & ~reset);

  mdu_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_c & is_mdu_c),
    .load_val (load_val_c),
    .dec      (state == ST_BUSY),
    .zero     (cnt_zero_c)
  );

  // Sequencer: single-cycle ops stay IDLE, MUL/DIV hold BUSY until done or flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ALU_Control <= '0;
      valid_q     <= 1'b0;
      MDU_Start   <= 1'b0;
      Illegal     <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      MDU_Start <= 1'b0;
      Illegal   <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept_c) begin
          ALU_Control <= CTRL_W'(dec_c.op);
          if (is_mdu_c) begin
            state     <= ST_BUSY;
            MDU_Start <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            Illegal <= dec_c.illegal;
          end
        end
      end else begin
        if (Flush || cnt_zero_c) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
